axis_accel_mux_n: RTL and testbench
===================================

# axis_accel_mux_n

Parametrised N-way AXI4-Stream accelerator selector with transaction-safe switching. It sits between the DMA-facing stream/ap_ctrl pair and N reconfigurable accelerator slots. It latches the selected slot only when idle, then routes start, done and both streams to that slot for one complete transaction. The transaction ends on accelerator done plus the last output beat. It also reports per-transaction beat counts and selection errors.

## Interface
Parameters:
- `DATA_W`, 128, stream data width.
- `N_ACCEL`, 2, number of accelerator slots (2..16).
- `SEL_W`, `$clog2(N_ACCEL)` (min 1), selector width.
- `CNT_W`, 32, beat counter width.

Ports (clock and reset first; one clock `ap_clk`, reset `ap_rst` asynchronous active-high):
- `ap_clk` in 1: sole clock.
- `ap_rst` in 1: async active-high reset.
- `sel_req` in SEL_W: requested slot, sampled with `ap_start`.
- `ap_start` in 1: one-cycle start pulse from host.
- `ap_done` out 1: one-cycle transaction-complete pulse.
- `busy` out 1: high outside IDLE.
- `cur_sel` out SEL_W: latched slot.
- `err_sel` out 1: one-cycle pulse, out-of-range `sel_req` at start.
- `err_busy` out 1: one-cycle pulse, `ap_start` while busy.
- `in_TDATA` in DATA_W, `in_TVALID` in 1, `in_TLAST` in 1, `in_TREADY` out 1: upstream slave.
- `acc_in_TDATA` out N_ACCEL*DATA_W, `acc_in_TVALID` out N_ACCEL, `acc_in_TLAST` out N_ACCEL, `acc_in_TREADY` in N_ACCEL: per-slot input masters.
- `acc_out_TDATA` in N_ACCEL*DATA_W, `acc_out_TVALID` in N_ACCEL, `acc_out_TLAST` in N_ACCEL, `acc_out_TREADY` out N_ACCEL: per-slot output slaves.
- `out_TDATA` out DATA_W, `out_TVALID` out 1, `out_TLAST` out 1, `out_TREADY` in 1: downstream master.
- `ap_start_acc` out N_ACCEL: per-slot start pulse.
- `ap_done_acc` in N_ACCEL: per-slot done pulse.
- `in_beats`, `out_beats` out CNT_W: accepted beats in current/last transaction.

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE, `ap_start`=1, `sel_req`<N_ACCEL:
  - latch `cur_sel`, clear counters and `done_seen`/`last_seen`, go RUN.
  - drive `ap_start_acc[cur_sel]`=1 for exactly one cycle.
- IDLE, `ap_start`=1, `sel_req`>=N_ACCEL: `err_sel` pulse, stay IDLE, no start, counters untouched.
- RUN: `ap_done_acc[cur_sel]` sets `done_seen`. An output handshake with `out_TLAST` sets `last_seen`. When `done_seen` is set, go DRAIN, or finish if both flags are set.
- DRAIN: wait for `last_seen`, then pulse `ap_done` and return to IDLE.
- If done and last occur in the same cycle, finish directly from RUN.
- `ap_done_acc` of non-selected slots is ignored.
- `ap_start` in RUN/DRAIN: ignored, `err_busy` pulse.
- Datapath (RUN/DRAIN only, combinational, zero latency):
  - `in_*` goes to slot `cur_sel`; `in_TREADY`=`acc_in_TREADY[cur_sel]`.
  - slot `cur_sel` output goes to `out_*`; `acc_out_TREADY[cur_sel]`=`out_TREADY`.
  - `acc_in_TDATA` is broadcast to all slots.
  - Every other VALID/READY is 0. In IDLE all VALID/READY are 0.
- Counters increment on handshakes and saturate at all-ones (no wrap). They hold after `ap_done` until the next accepted start.

## Timing
- Reset values: state IDLE; `cur_sel`=0; `ap_done`, `busy`, `err_*`, `ap_start_acc`=0; counters=0; flags clear. All stream VALID/READY outputs are 0.
- Start accepted at cycle t: `ap_start_acc[sel]`, `busy` and RUN all take effect at t+1. Stream routing is live from t+1.
- Completion condition true at cycle t: `ap_done` is high at t+1 and IDLE holds at t+1. A new `ap_start` at t+1 is accepted.
- Reset mid-transaction: all outputs return to reset values immediately (async). Accelerator state is not managed here.

## Structure
- Package `axis_accel_mux_pkg`: state enum, `SEL_W` helper function, `DATA_W_DEF`/`CNT_W_DEF` constants.
- Sub-module `axis_accel_mux_ctrl`: FSM, flags, error pulses, saturating counters. The top level holds the routing muxes.

## Test plan
- N_ACCEL=4, start sel=2, 8 in beats, accelerator returns 8 beats with TLAST then done: `ap_start_acc`=4'b0100 for 1 cycle; `in_beats`=`out_beats`=8; `ap_done` 1 cycle after done.
- Done before TLAST: done at t, TLAST accepted at t+5 -> DRAIN t+1..t+5, `ap_done` at t+6.
- Done and TLAST handshake in the same cycle t -> `ap_done` at t+1, no DRAIN cycle.
- Start sel=5 with N_ACCEL=4 -> `err_sel` 1 cycle, `busy`=0, no `ap_start_acc`. Start during RUN -> `err_busy`; `cur_sel` unchanged; stray `ap_done_acc[0]` with sel=1 ignored.
- CNT_W=4, 20 in beats -> `in_beats`=15. Async `ap_rst` mid-RUN -> all VALID/READY 0, `busy`=0 the same cycle.

Source files
------------

// File: rtl/axis_accel_mux_pkg.sv
// Shared types and constants for the N-way AXI4-Stream accelerator selector.
package axis_accel_mux_pkg;

   localparam int unsigned DATA_W_DEF = 128;
   localparam int unsigned CNT_W_DEF  = 32;

   // Transaction state: IDLE accepts starts, RUN streams, DRAIN waits for the final output beat.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Selector width for n slots, never narrower than one bit.
   function automatic int unsigned sel_w_f(input int unsigned n);
      return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
   endfunction

endpackage

// File: rtl/axis_accel_mux_ctrl.sv
// Transaction controller: slot latch, completion tracking, error pulses and beat counters.
module axis_accel_mux_ctrl
   import axis_accel_mux_pkg::*;
#(
   parameter int unsigned N_ACCEL = 2,
   parameter int unsigned SEL_W   = 1,
   parameter int unsigned CNT_W   = CNT_W_DEF
) (
   input  logic               ap_clk,
   input  logic               ap_rst,
   input  logic [SEL_W-1:0]   sel_req,
   input  logic               ap_start,
   input  logic [N_ACCEL-1:0] ap_done_acc,
   input  logic               in_hs,
   input  logic               out_hs,
   input  logic               out_last_hs,
   output logic               ap_done,
   output logic               busy,
   output logic [SEL_W-1:0]   cur_sel,
   output logic               err_sel,
   output logic               err_busy,
   output logic [N_ACCEL-1:0] ap_start_acc,
   output logic [CNT_W-1:0]   in_beats,
   output logic [CNT_W-1:0]   out_beats
);

   state_t             state, state_nx;
   logic [SEL_W-1:0]   cur_sel_nx;
   logic               done_seen, done_seen_nx;
   logic               last_seen, last_seen_nx;
   logic               ap_done_nx, err_sel_nx, err_busy_nx;
   logic [N_ACCEL-1:0] start_acc_nx;
   logic [N_ACCEL-1:0] req_onehot;
   logic               done_sel, sel_ok, clr_cnt;
   logic               done_hit, last_hit;

   // Decode the requested slot and pick the done pulse of the latched slot only.
   always_comb begin
      done_sel   = 1'b0;
      req_onehot = '0;
      for (int i = 0; i < int'(N_ACCEL); i++) begin
         if (cur_sel == SEL_W'(i)) done_sel = ap_done_acc[i];
         if (sel_req == SEL_W'(i)) req_onehot[i] = 1'b1;
      end
      sel_ok = 32'(sel_req) < N_ACCEL;
   end

   // Next-state and next-output logic.
   always_comb begin
      state_nx     = state;
      cur_sel_nx   = cur_sel;
      done_seen_nx = done_seen;
      last_seen_nx = last_seen;
      ap_done_nx   = 1'b0;
      err_sel_nx   = 1'b0;
      err_busy_nx  = 1'b0;
      start_acc_nx = '0;
      clr_cnt      = 1'b0;
      done_hit     = done_seen | done_sel;
      last_hit     = last_seen | out_last_hs;
      case (state)
         IDLE: begin
            if (ap_start) begin
               if (sel_ok) begin
                  state_nx     = RUN;
                  cur_sel_nx   = sel_req;
                  done_seen_nx = 1'b0;
                  last_seen_nx = 1'b0;
                  start_acc_nx = req_onehot;
                  clr_cnt      = 1'b1;
               end else begin
                  err_sel_nx = 1'b1;
               end
            end
         end
         RUN: begin
            err_busy_nx  = ap_start;
            done_seen_nx = done_hit;
            last_seen_nx = last_hit;
            if (done_hit && last_hit) begin
               state_nx   = IDLE;
               ap_done_nx = 1'b1;
            end else if (done_hit) begin
               state_nx = DRAIN;
            end
         end
         DRAIN: begin
            err_busy_nx  = ap_start;
            last_seen_nx = last_hit;
            if (last_hit) begin
               state_nx   = IDLE;
               ap_done_nx = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // State and registered control outputs.
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         state        <= IDLE;
         cur_sel      <= '0;
         done_seen    <= 1'b0;
         last_seen    <= 1'b0;
         ap_done      <= 1'b0;
         busy         <= 1'b0;
         err_sel      <= 1'b0;
         err_busy     <= 1'b0;
         ap_start_acc <= '0;
      end else begin
         state        <= state_nx;
         cur_sel      <= cur_sel_nx;
         done_seen    <= done_seen_nx;
         last_seen    <= last_seen_nx;
         ap_done      <= ap_done_nx;
         busy         <= (state_nx != IDLE);
         err_sel      <= err_sel_nx;
         err_busy     <= err_busy_nx;
         ap_start_acc <= start_acc_nx;
      end
   end

   // Saturating beat counters, cleared by an accepted start and held otherwise.
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         in_beats  <= '0;
         out_beats <= '0;
      end else if (clr_cnt) begin
         in_beats  <= '0;
         out_beats <= '0;
      end else begin
         if (in_hs && (in_beats != '1))   in_beats  <= in_beats + CNT_W'(1);
         if (out_hs && (out_beats != '1)) out_beats <= out_beats + CNT_W'(1);
      end
   end

endmodule

// File: rtl/axis_accel_mux_n.sv
// N-way AXI4-Stream accelerator selector; routes host streams and control to one latched slot.
module axis_accel_mux_n
   import axis_accel_mux_pkg::*;
#(
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned N_ACCEL = 2,
   parameter int unsigned SEL_W   = sel_w_f(N_ACCEL),
   parameter int unsigned CNT_W   = CNT_W_DEF
) (
   input  logic                       ap_clk,
   input  logic                       ap_rst,
   input  logic [SEL_W-1:0]           sel_req,
   input  logic                       ap_start,
   output logic                       ap_done,
   output logic                       busy,
   output logic [SEL_W-1:0]           cur_sel,
   output logic                       err_sel,
   output logic                       err_busy,
   input  logic [DATA_W-1:0]          in_TDATA,
   input  logic                       in_TVALID,
   input  logic                       in_TLAST,
   output logic                       in_TREADY,
   output logic [N_ACCEL*DATA_W-1:0]  acc_in_TDATA,
   output logic [N_ACCEL-1:0]         acc_in_TVALID,
   output logic [N_ACCEL-1:0]         acc_in_TLAST,
   input  logic [N_ACCEL-1:0]         acc_in_TREADY,
   input  logic [N_ACCEL*DATA_W-1:0]  acc_out_TDATA,
   input  logic [N_ACCEL-1:0]         acc_out_TVALID,
   input  logic [N_ACCEL-1:0]         acc_out_TLAST,
   output logic [N_ACCEL-1:0]         acc_out_TREADY,
   output logic [DATA_W-1:0]          out_TDATA,
   output logic                       out_TVALID,
   output logic                       out_TLAST,
   input  logic                       out_TREADY,
   output logic [N_ACCEL-1:0]         ap_start_acc,
   input  logic [N_ACCEL-1:0]         ap_done_acc,
   output logic [CNT_W-1:0]           in_beats,
   output logic [CNT_W-1:0]           out_beats
);

   logic in_hs, out_hs, out_last_hs;

   axis_accel_mux_ctrl #(
      .N_ACCEL (N_ACCEL),
      .SEL_W   (SEL_W),
      .CNT_W   (CNT_W)
   ) u_ctrl (
      .ap_clk       (ap_clk),
      .ap_rst       (ap_rst),
      .sel_req      (sel_req),
      .ap_start     (ap_start),
      .ap_done_acc  (ap_done_acc),
      .in_hs        (in_hs),
      .out_hs       (out_hs),
      .out_last_hs  (out_last_hs),
      .ap_done      (ap_done),
      .busy         (busy),
      .cur_sel      (cur_sel),
      .err_sel      (err_sel),
      .err_busy     (err_busy),
      .ap_start_acc (ap_start_acc),
      .in_beats     (in_beats),
      .out_beats    (out_beats)
   );

   // Input data fans out to every slot; only the selected slot ever sees VALID.
   assign acc_in_TDATA = {N_ACCEL{in_TDATA}};

   // Zero-latency routing to and from the latched slot while a transaction is open.
   always_comb begin
      acc_in_TVALID  = '0;
      acc_in_TLAST   = '0;
      acc_out_TREADY = '0;
      in_TREADY      = 1'b0;
      out_TDATA      = '0;
      out_TVALID     = 1'b0;
      out_TLAST      = 1'b0;
      for (int i = 0; i < int'(N_ACCEL); i++) begin
         if (busy && (cur_sel == SEL_W'(i))) begin
            acc_in_TVALID[i]  = in_TVALID;
            acc_in_TLAST[i]   = in_TLAST;
            in_TREADY         = acc_in_TREADY[i];
            out_TDATA         = acc_out_TDATA[i*DATA_W +: DATA_W];
            out_TVALID        = acc_out_TVALID[i];
            out_TLAST         = acc_out_TLAST[i];
            acc_out_TREADY[i] = out_TREADY;
         end
      end
      in_hs       = in_TVALID & in_TREADY;
      out_hs      = out_TVALID & out_TREADY;
      out_last_hs = out_hs & out_TLAST;
   end

endmodule

// File: tb/tb_axis_accel_mux_n.sv
// Self-checking bench for axis_accel_mux_n: host, downstream sink and four accelerator slots are modelled here.
module tb_axis_accel_mux_n;

   localparam int unsigned DW = 16;
   localparam int unsigned NA = 4;
   localparam int unsigned SW = 3;
   localparam int unsigned CW = 4;

   logic clk = 1'b0;
   logic ap_rst = 1'b1;
   logic [SW-1:0]    sel_req;
   logic             ap_start, ap_done, busy, err_sel, err_busy;
   logic [SW-1:0]    cur_sel;
   logic [DW-1:0]    in_TDATA, out_TDATA;
   logic             in_TVALID, in_TLAST, in_TREADY;
   logic             out_TVALID, out_TLAST, out_TREADY;
   logic [NA*DW-1:0] acc_in_TDATA, acc_out_TDATA;
   logic [NA-1:0]    acc_in_TVALID, acc_in_TLAST, acc_in_TREADY;
   logic [NA-1:0]    acc_out_TVALID, acc_out_TLAST, acc_out_TREADY;
   logic [NA-1:0]    ap_start_acc, ap_done_acc;
   logic [CW-1:0]    in_beats, out_beats;

   int tests = 0;
   int fails = 0;
   int exp_in = 0;
   int exp_out = 0;

   always #5 clk = ~clk;

   axis_accel_mux_n #(.DATA_W(DW), .N_ACCEL(NA), .SEL_W(SW), .CNT_W(CW)) dut (
      .ap_clk(clk), .ap_rst(ap_rst), .sel_req(sel_req), .ap_start(ap_start),
      .ap_done(ap_done), .busy(busy), .cur_sel(cur_sel), .err_sel(err_sel), .err_busy(err_busy),
      .in_TDATA(in_TDATA), .in_TVALID(in_TVALID), .in_TLAST(in_TLAST), .in_TREADY(in_TREADY),
      .acc_in_TDATA(acc_in_TDATA), .acc_in_TVALID(acc_in_TVALID), .acc_in_TLAST(acc_in_TLAST),
      .acc_in_TREADY(acc_in_TREADY), .acc_out_TDATA(acc_out_TDATA), .acc_out_TVALID(acc_out_TVALID),
      .acc_out_TLAST(acc_out_TLAST), .acc_out_TREADY(acc_out_TREADY), .out_TDATA(out_TDATA),
      .out_TVALID(out_TVALID), .out_TLAST(out_TLAST), .out_TREADY(out_TREADY),
      .ap_start_acc(ap_start_acc), .ap_done_acc(ap_done_acc), .in_beats(in_beats), .out_beats(out_beats)
   );

   // Saturating count the counters should report after n accepted beats.
   function automatic int satc(input int n);
      int m;
      m = (1 << CW) - 1;
      return (n > m) ? m : n;
   endfunction

   function automatic logic [NA-1:0] onehot(input int sel);
      logic [NA-1:0] v;
      v = '0;
      v[sel] = 1'b1;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_acc();
      acc_in_TREADY = '0; acc_out_TVALID = '0; acc_out_TLAST = '0; acc_out_TDATA = '0;
      out_TREADY = 1'b0; ap_done_acc = '0; in_TVALID = 1'b0; in_TLAST = 1'b0;
   endtask

   task automatic start(input int sel);
      sel_req = SW'(sel);
      ap_start = 1'b1;
      tick();
      ap_start = 1'b0;
   endtask

   task automatic pulse_done(input int sel);
      ap_done_acc = onehot(sel);
      tick();
      ap_done_acc = '0;
   endtask

   // Final output beat with TLAST handshaking in the same cycle as the slot's done pulse.
   task automatic last_and_done(input int sel);
      acc_out_TDATA = {NA{DW'($urandom)}};
      acc_out_TVALID = onehot(sel);
      acc_out_TLAST = onehot(sel);
      out_TREADY = 1'b1;
      ap_done_acc = onehot(sel);
      tick();
      clear_acc();
   endtask

   // Host pushes n beats with random VALID; slot sel accepts with random READY.
   task automatic stream_in(input int sel, input int n, output int got, output int errs);
      int budget;
      logic [DW-1:0] d;
      got = 0; errs = 0; budget = 0;
      while (got < n && budget < 2000) begin
         d = DW'($urandom);
         in_TDATA = d;
         in_TVALID = ($urandom % 4) != 0;
         in_TLAST = (got == n - 1);
         acc_in_TREADY = NA'($urandom);
         @(negedge clk);
         if (in_TREADY !== acc_in_TREADY[sel] || acc_in_TVALID !== (in_TVALID ? onehot(sel) : '0)) errs++;
         if (acc_out_TREADY !== '0) errs++;
         if (in_TVALID && acc_in_TREADY[sel]) begin
            if (acc_in_TDATA[sel*DW +: DW] !== d || acc_in_TLAST[sel] !== in_TLAST) errs++;
            got++;
         end
         tick();
         budget++;
      end
      clear_acc();
   endtask

   // Slot sel returns n beats (TLAST on the last when with_last); other slots drive noise.
   task automatic stream_out(input int sel, input int n, input bit with_last, output int got, output int errs);
      int budget;
      logic [DW-1:0] d;
      logic lst;
      got = 0; errs = 0; budget = 0;
      while (got < n && budget < 2000) begin
         for (int i = 0; i < int'(NA); i++) acc_out_TDATA[i*DW +: DW] = DW'($urandom);
         d = acc_out_TDATA[sel*DW +: DW];
         acc_out_TVALID = NA'($urandom);
         acc_out_TLAST = NA'($urandom);
         lst = with_last && (got == n - 1);
         acc_out_TLAST[sel] = lst;
         out_TREADY = ($urandom % 4) != 0;
         @(negedge clk);
         if (out_TVALID !== acc_out_TVALID[sel] || acc_out_TREADY !== (out_TREADY ? onehot(sel) : '0)) errs++;
         if (acc_out_TVALID[sel] && out_TREADY) begin
            if (out_TDATA !== d || out_TLAST !== lst) errs++;
            got++;
         end
         tick();
         budget++;
      end
      clear_acc();
   endtask

   task automatic test_reset();
      ap_rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      tests++;
      if ({busy, ap_done, err_sel, err_busy, cur_sel, ap_start_acc} !== '0) begin
         fails++;
         $display("FAIL reset_ctrl: busy=%b done=%b es=%b eb=%b sel=%0d sacc=%b want all 0",
                  busy, ap_done, err_sel, err_busy, cur_sel, ap_start_acc);
      end
      tests++;
      if ({in_beats, out_beats, in_TREADY, out_TVALID, acc_in_TVALID, acc_out_TREADY} !== '0) begin
         fails++;
         $display("FAIL reset_stream: inb=%0d outb=%0d irdy=%b ovld=%b aiv=%b aor=%b want all 0",
                  in_beats, out_beats, in_TREADY, out_TVALID, acc_in_TVALID, acc_out_TREADY);
      end
      @(posedge clk);
      #1 ap_rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      int got, errs;
      start(2);
      tests++;
      if (ap_start_acc !== 4'b0100 || busy !== 1'b1 || cur_sel !== 3'd2) begin
         fails++;
         $display("FAIL basic_start: sacc=%b busy=%b sel=%0d want 0100 1 2", ap_start_acc, busy, cur_sel);
      end
      tick();
      tests++;
      if (ap_start_acc !== 4'b0000) begin
         fails++;
         $display("FAIL basic_start_width: sacc=%b want 0000", ap_start_acc);
      end
      stream_in(2, 8, got, errs);
      tests++;
      if (got != 8 || errs != 0 || in_beats !== 4'd8) begin
         fails++;
         $display("FAIL basic_in: got=%0d errs=%0d in_beats=%0d want 8 0 8", got, errs, in_beats);
      end
      stream_out(2, 8, 1'b1, got, errs);
      tests++;
      if (got != 8 || errs != 0 || out_beats !== 4'd8 || busy !== 1'b1 || ap_done !== 1'b0) begin
         fails++;
         $display("FAIL basic_out: got=%0d errs=%0d out_beats=%0d busy=%b done=%b want 8 0 8 1 0",
                  got, errs, out_beats, busy, ap_done);
      end
      pulse_done(2);
      tests++;
      if (ap_done !== 1'b1 || busy !== 1'b0) begin
         fails++;
         $display("FAIL basic_done: done=%b busy=%b want 1 0", ap_done, busy);
      end
      tick();
      tests++;
      if (ap_done !== 1'b0 || in_beats !== 4'd8 || out_beats !== 4'd8) begin
         fails++;
         $display("FAIL basic_hold: done=%b inb=%0d outb=%0d want 0 8 8", ap_done, in_beats, out_beats);
      end
      exp_in = 8; exp_out = 8;
   endtask

   task automatic test_drain();
      int got, errs, sel, n;
      sel = int'($urandom_range(0, 3));
      n = int'($urandom_range(2, 6));
      start(sel);
      stream_out(sel, n - 1, 1'b0, got, errs);
      pulse_done(sel);
      for (int k = 1; k <= 5; k++) begin
         if (k == 5) begin
            acc_out_TDATA = {NA{DW'($urandom)}};
            acc_out_TVALID = onehot(sel);
            acc_out_TLAST = onehot(sel);
            out_TREADY = 1'b1;
         end
         tests++;
         if (busy !== 1'b1 || ap_done !== 1'b0) begin
            fails++;
            $display("FAIL drain_wait_%0d: busy=%b done=%b want 1 0", k, busy, ap_done);
         end
         tick();
      end
      clear_acc();
      tests++;
      if (ap_done !== 1'b1 || busy !== 1'b0 || out_beats !== CW'(satc(n)) || errs != 0) begin
         fails++;
         $display("FAIL drain_done: done=%b busy=%b outb=%0d errs=%0d want 1 0 %0d 0",
                  ap_done, busy, out_beats, errs, satc(n));
      end
      tick();
      exp_in = 0; exp_out = n;
   endtask

   task automatic test_same_cycle();
      int got, errs, sel;
      sel = int'($urandom_range(0, 3));
      start(sel);
      stream_out(sel, 2, 1'b0, got, errs);
      last_and_done(sel);
      tests++;
      if (ap_done !== 1'b1 || busy !== 1'b0 || out_beats !== 4'd3) begin
         fails++;
         $display("FAIL same_cycle: done=%b busy=%b outb=%0d want 1 0 3", ap_done, busy, out_beats);
      end
   endtask

   // Starts in the very cycle ap_done is high, right after test_same_cycle returns.
   task automatic test_back_to_back();
      int got, errs, sel;
      sel = int'($urandom_range(0, 3));
      start(sel);
      tests++;
      if (busy !== 1'b1 || ap_start_acc !== onehot(sel) || in_beats !== 4'd0 || out_beats !== 4'd0) begin
         fails++;
         $display("FAIL b2b_start: busy=%b sacc=%b inb=%0d outb=%0d want 1 %b 0 0",
                  busy, ap_start_acc, in_beats, out_beats, onehot(sel));
      end
      stream_in(sel, 3, got, errs);
      last_and_done(sel);
      tests++;
      if (ap_done !== 1'b1 || in_beats !== 4'd3 || out_beats !== 4'd1 || errs != 0) begin
         fails++;
         $display("FAIL b2b_done: done=%b inb=%0d outb=%0d errs=%0d want 1 3 1 0", ap_done, in_beats, out_beats, errs);
      end
      tick();
      exp_in = 3; exp_out = 1;
   endtask

   task automatic test_errors();
      int got, errs;
      start(5);
      tests++;
      if (err_sel !== 1'b1 || busy !== 1'b0 || ap_start_acc !== '0 ||
          in_beats !== CW'(exp_in) || out_beats !== CW'(exp_out)) begin
         fails++;
         $display("FAIL err_sel: es=%b busy=%b sacc=%b inb=%0d outb=%0d want 1 0 0000 %0d %0d",
                  err_sel, busy, ap_start_acc, in_beats, out_beats, exp_in, exp_out);
      end
      tick();
      tests++;
      if (err_sel !== 1'b0) begin
         fails++;
         $display("FAIL err_sel_width: es=%b want 0", err_sel);
      end
      start(1);
      start(3);
      tests++;
      if (err_busy !== 1'b1 || cur_sel !== 3'd1 || ap_start_acc !== '0) begin
         fails++;
         $display("FAIL err_busy: eb=%b sel=%0d sacc=%b want 1 1 0000", err_busy, cur_sel, ap_start_acc);
      end
      tick();
      tests++;
      if (err_busy !== 1'b0) begin
         fails++;
         $display("FAIL err_busy_width: eb=%b want 0", err_busy);
      end
      stream_out(1, 2, 1'b1, got, errs);
      pulse_done(0);
      tests++;
      if (busy !== 1'b1 || ap_done !== 1'b0) begin
         fails++;
         $display("FAIL stray_done: busy=%b done=%b want 1 0", busy, ap_done);
      end
      pulse_done(1);
      tests++;
      if (ap_done !== 1'b1 || busy !== 1'b0 || errs != 0) begin
         fails++;
         $display("FAIL err_finish: done=%b busy=%b errs=%0d want 1 0 0", ap_done, busy, errs);
      end
      tick();
   endtask

   task automatic test_saturation();
      int got, errs, sel;
      sel = int'($urandom_range(0, 3));
      start(sel);
      stream_in(sel, 20, got, errs);
      tests++;
      if (got != 20 || errs != 0 || in_beats !== 4'd15) begin
         fails++;
         $display("FAIL sat_in: got=%0d errs=%0d inb=%0d want 20 0 15", got, errs, in_beats);
      end
      stream_out(sel, 3, 1'b1, got, errs);
      pulse_done(sel);
      tests++;
      if (ap_done !== 1'b1 || in_beats !== 4'd15 || out_beats !== 4'd3) begin
         fails++;
         $display("FAIL sat_done: done=%b inb=%0d outb=%0d want 1 15 3", ap_done, in_beats, out_beats);
      end
      tick();
   endtask

   // Random transactions: random slot, beat counts and ordering of done versus final TLAST.
   task automatic test_random();
      int got, errs, sel, n_in, n_out, mode, gap;
      for (int it = 0; it < 12; it++) begin
         sel = int'($urandom_range(0, 3));
         n_in = int'($urandom_range(1, 18));
         n_out = int'($urandom_range(1, 18));
         mode = int'($urandom_range(0, 2));
         start(sel);
         tests++;
         if (ap_start_acc !== onehot(sel) || cur_sel !== SW'(sel)) begin
            fails++;
            $display("FAIL rnd%0d_start: sacc=%b sel=%0d want %b %0d", it, ap_start_acc, cur_sel, onehot(sel), sel);
         end
         stream_in(sel, n_in, got, errs);
         tests++;
         if (got != n_in || errs != 0 || in_beats !== CW'(satc(n_in))) begin
            fails++;
            $display("FAIL rnd%0d_in: got=%0d errs=%0d inb=%0d want %0d 0 %0d", it, got, errs, in_beats, n_in, satc(n_in));
         end
         if (mode == 0) begin
            stream_out(sel, n_out, 1'b1, got, errs);
            gap = int'($urandom_range(0, 3));
            repeat (gap) tick();
            tests++;
            if (busy !== 1'b1 || ap_done !== 1'b0) begin
               fails++;
               $display("FAIL rnd%0d_wait_done: busy=%b done=%b want 1 0", it, busy, ap_done);
            end
            pulse_done(sel);
         end else if (mode == 1) begin
            pulse_done(sel);
            stream_out(sel, n_out, 1'b1, got, errs);
         end else begin
            stream_out(sel, n_out - 1, 1'b0, got, errs);
            last_and_done(sel);
            got++;
         end
         tests++;
         if (ap_done !== 1'b1 || busy !== 1'b0 || got != n_out || errs != 0 || out_beats !== CW'(satc(n_out))) begin
            fails++;
            $display("FAIL rnd%0d_done mode%0d: done=%b busy=%b got=%0d errs=%0d outb=%0d want 1 0 %0d 0 %0d",
                     it, mode, ap_done, busy, got, errs, out_beats, n_out, satc(n_out));
         end
         tick();
      end
   endtask

   task automatic test_async_reset();
      start(3);
      in_TVALID = 1'b1;
      acc_in_TREADY = '1;
      acc_out_TVALID = '1;
      out_TREADY = 1'b1;
      #1;
      tests++;
      if (acc_in_TVALID !== 4'b1000 || in_TREADY !== 1'b1 || acc_out_TREADY !== 4'b1000) begin
         fails++;
         $display("FAIL rst_live: aiv=%b irdy=%b aor=%b want 1000 1 1000", acc_in_TVALID, in_TREADY, acc_out_TREADY);
      end
      ap_rst = 1'b1;
      #1;
      tests++;
      if ({acc_in_TVALID, acc_out_TREADY, in_TREADY, out_TVALID, busy, cur_sel, ap_start_acc} !== '0) begin
         fails++;
         $display("FAIL rst_async: aiv=%b aor=%b irdy=%b ovld=%b busy=%b sel=%0d sacc=%b want all 0",
                  acc_in_TVALID, acc_out_TREADY, in_TREADY, out_TVALID, busy, cur_sel, ap_start_acc);
      end
      clear_acc();
      @(posedge clk);
      #1 ap_rst = 1'b0;
      tick();
   endtask

   initial begin
      sel_req = '0; ap_start = 1'b0; in_TDATA = '0;
      clear_acc();
      test_reset();
      test_basic();
      test_drain();
      test_same_cycle();
      test_back_to_back();
      test_errors();
      test_saturation();
      test_random();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
